// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter for the keyboard port.
// Sends one byte with the inhibit / request-to-send sequence and checks
// the device ACK. The open-drain lines are driven through pull-low enables.
//
// Ports:
//   Clk        in   system clock
//   Reset      in   synchronous active-high reset
//   PS2_KBCLK  in   raw PS/2 clock pin level (asynchronous)
//   PS2_KBDAT  in   raw PS/2 data pin level (asynchronous)
//   Start      in   one-cycle transmit request, accepted only when idle
//   Data       in   command byte, captured on the accepted Start
//   ClkOE      out  1 = pull PS2_KBCLK low
//   DatOE      out  1 = pull PS2_KBDAT low
//   Busy       out  high from accepted Start until Done/Error
//   Done       out  one-cycle pulse after ACK and bus idle
//   Error      out  one-cycle pulse on timeout or missing ACK
//   RxInhibit  out  copy of Busy; receive path discards frames while high
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 6000,
  parameter int unsigned TIMEOUT_CYCLES = 750000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       PS2_KBCLK,
  input  logic       PS2_KBDAT,
  input  logic       Start,
  input  logic [7:0] Data,
  output logic       ClkOE,
  output logic       DatOE,
  output logic       Busy,
  output logic       Done,
  output logic       Error,
  output logic       RxInhibit
);

  localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ?
                                    INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned BIT_W   = 4;

  localparam logic [CNT_W-1:0] INHIBIT_LOAD = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [BIT_W-1:0] BIT_PARITY   = BIT_W'(8);
  localparam logic [BIT_W-1:0] BIT_STOP     = BIT_W'(9);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INHIBIT   = 3'd1,
    S_RTS       = 3'd2,
    S_XFER      = 3'd3,
    S_WAIT_IDLE = 3'd4,
    S_DONE      = 3'd5,
    S_ERR       = 3'd6
  } state_t;

  // Synchronizers and clock-edge history
  logic r_clk_s1, r_clk_s2, r_clk_prev;
  logic r_dat_s1, r_dat_s2;
  logic w_fe;

  // FSM and datapath state
  state_t           r_state,  w_state_nxt;
  logic [CNT_W-1:0] r_cnt,    w_cnt_nxt;
  logic [BIT_W-1:0] r_bitcnt, w_bitcnt_nxt;
  logic [7:0]       r_shift,  w_shift_nxt;
  logic             r_parity, w_parity_nxt;
  logic             w_cnt_zero;

  // Registered outputs
  logic r_clkoe, w_clkoe_nxt;
  logic r_datoe, w_datoe_nxt;
  logic r_busy,  w_busy_nxt;
  logic r_done,  w_done_nxt;
  logic r_error, w_error_nxt;

  // Two-flop synchronizers; idle bus level is high, so reset to 1
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_clk_prev <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_dat_s2   <= 1'b1;
    end else begin
      r_clk_s1   <= PS2_KBCLK;
      r_clk_s2   <= r_clk_s1;
      r_clk_prev <= r_clk_s2;
      r_dat_s1   <= PS2_KBDAT;
      r_dat_s2   <= r_dat_s1;
    end
  end

  assign w_fe       = r_clk_prev & ~r_clk_s2;
  assign w_cnt_zero = (r_cnt == '0);

  // State and datapath registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_parity <= 1'b0;
      r_clkoe  <= 1'b0;
      r_datoe  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_shift  <= w_shift_nxt;
      r_parity <= w_parity_nxt;
      r_clkoe  <= w_clkoe_nxt;
      r_datoe  <= w_datoe_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_error  <= w_error_nxt;
    end
  end

  // Next-state, datapath and next-output logic
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_bitcnt_nxt = r_bitcnt;
    w_shift_nxt  = r_shift;
    w_parity_nxt = r_parity;
    w_datoe_nxt  = 1'b0;
    w_clkoe_nxt  = 1'b0;
    w_busy_nxt   = 1'b0;
    w_done_nxt   = 1'b0;
    w_error_nxt  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (Start) begin
          w_state_nxt  = S_INHIBIT;
          w_cnt_nxt    = INHIBIT_LOAD;
          w_shift_nxt  = Data;
          w_parity_nxt = ~^Data;
          w_bitcnt_nxt = '0;
        end
      end

      S_INHIBIT: begin
        if (w_cnt_zero) begin
          w_state_nxt = S_RTS;
          w_datoe_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end

      // Start bit is already on the line; release clock and arm timeout
      S_RTS: begin
        w_state_nxt  = S_XFER;
        w_cnt_nxt    = TIMEOUT_LOAD;
        w_bitcnt_nxt = '0;
        w_datoe_nxt  = 1'b1;
      end

      // Each device falling edge advances one bit; fe #11 samples the ACK
      S_XFER: begin
        w_datoe_nxt = r_datoe;
        if (w_fe) begin
          w_cnt_nxt    = TIMEOUT_LOAD;
          w_bitcnt_nxt = r_bitcnt + BIT_W'(1);
          if (r_bitcnt < BIT_PARITY) begin
            w_datoe_nxt = ~r_shift[0];
            w_shift_nxt = {1'b0, r_shift[7:1]};
          end else if (r_bitcnt == BIT_PARITY) begin
            w_datoe_nxt = ~r_parity;
          end else if (r_bitcnt == BIT_STOP) begin
            w_datoe_nxt = 1'b0;
          end else begin
            w_datoe_nxt = 1'b0;
            w_state_nxt = r_dat_s2 ? S_ERR : S_WAIT_IDLE;
          end
        end else if (w_cnt_zero) begin
          w_state_nxt = S_ERR;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end

      // Device must release both lines before the frame counts as done
      S_WAIT_IDLE: begin
        if (r_clk_s2 && r_dat_s2) begin
          w_state_nxt = S_DONE;
        end else if (w_fe) begin
          w_cnt_nxt = TIMEOUT_LOAD;
        end else if (w_cnt_zero) begin
          w_state_nxt = S_ERR;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end

      S_DONE:  w_state_nxt = S_IDLE;
      S_ERR:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    // Outputs follow the state being entered so they line up with it
    w_clkoe_nxt = (w_state_nxt == S_INHIBIT) || (w_state_nxt == S_RTS);
    w_busy_nxt  = (w_state_nxt == S_INHIBIT) || (w_state_nxt == S_RTS) ||
                  (w_state_nxt == S_XFER)    || (w_state_nxt == S_WAIT_IDLE);
    w_done_nxt  = (w_state_nxt == S_DONE);
    w_error_nxt = (w_state_nxt == S_ERR);
    if ((w_state_nxt != S_XFER) && (w_state_nxt != S_RTS)) begin
      w_datoe_nxt = 1'b0;
    end
  end

  assign ClkOE     = r_clkoe;
  assign DatOE     = r_datoe;
  assign Busy      = r_busy;
  assign Done      = r_done;
  assign Error     = r_error;
  assign RxInhibit = r_busy;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: models a PS/2 keyboard on open-drain lines with a
// 20-cycle device clock and compares captured frames against a byte-level
// reference built from the PS/2 framing rules.
module tb_ps2_host_tx;

  localparam int unsigned INH = 20;
  localparam int unsigned TMO = 200;

  localparam int M_ACK   = 0;
  localparam int M_NOACK = 1;
  localparam int M_STALL = 2;
  localparam int M_RESET = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] data;
  logic       clk_oe, dat_oe, busy, done, error, rx_inh;
  logic       dev_clk_low, dev_dat_low;
  wire        kbclk = ~(clk_oe | dev_clk_low);
  wire        kbdat = ~(dat_oe | dev_dat_low);

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_done  = 0;
  int n_err   = 0;
  int n_both  = 0;
  int n_rxmis = 0;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .Clk(clk), .Reset(rst), .PS2_KBCLK(kbclk), .PS2_KBDAT(kbdat),
    .Start(start), .Data(data), .ClkOE(clk_oe), .DatOE(dat_oe),
    .Busy(busy), .Done(done), .Error(error), .RxInhibit(rx_inh)
  );

  always #5 clk = ~clk;

  // Pulse monitor, sampled just after each active edge
  always @(posedge clk) begin
    #1;
    if (done) n_done++;
    if (error) n_err++;
    if (done && error) n_both++;
    if (rx_inh !== busy) n_rxmis++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_tests++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Frame as the device should see it: start, D0..D7, odd parity, stop
  function automatic logic [10:0] model_frame(input logic [7:0] d);
    logic [10:0] f;
    int ones;
    ones = 0;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      f[i+1] = ((int'(d) >> i) % 2) == 1;
      ones += (int'(d) >> i) % 2;
    end
    f[9]  = (ones % 2) == 0;
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic do_start(input logic [7:0] d);
    data  = d;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
  endtask

  // Device side of one frame; returns captured bits and measured intervals
  task automatic dev_frame(input int mode, input int stop_after, input int start_at,
                           output logic [10:0] cap, output int inh_len,
                           output int rts_len, output int err_delay);
    int guard;
    int fe_cyc;
    cap       = '1;
    inh_len   = 0;
    rts_len   = 0;
    err_delay = 0;
    fe_cyc    = cyc;
    guard     = 0;
    while (clk_oe && guard < 100) begin
      if (dat_oe) rts_len++;
      else inh_len++;
      tick();
      guard++;
    end
    if (guard >= 100) check("clkoe_release_timeout", 32'(guard), 32'd0);
    repeat (5) tick();
    cap[0] = kbdat;
    for (int i = 1; i <= 11; i++) begin
      if (mode == M_STALL && i > stop_after) break;
      dev_clk_low = 1'b1;
      fe_cyc = cyc;
      if (mode == M_RESET && i == stop_after) begin
        repeat (6) tick();
        return;
      end
      for (int k = 0; k < 10; k++) begin
        if (i == start_at && k == 0) begin
          start = 1'b1;
          data  = 8'hAA;
        end
        tick();
        start = 1'b0;
      end
      if (i <= 10) cap[i] = kbdat;
      dev_clk_low = 1'b0;
      if (i == 10 && mode == M_ACK) dev_dat_low = 1'b1;
      if (i == 11) dev_dat_low = 1'b0;
      repeat (10) tick();
    end
    if (mode == M_STALL) begin
      guard = 0;
      while (!error && guard < 400) begin
        tick();
        guard++;
      end
      err_delay = cyc - fe_cyc;
    end
  endtask

  typedef struct {
    logic [7:0] data;
    int         mode;
    int         stop_after;
    int         exp_done;
    int         exp_err;
    logic       exp_par;
  } vec_t;

  vec_t vecs[5];

  task automatic run_frame(input string tag, input logic [7:0] d, input int mode,
                           input int stop_after, input int start_at,
                           input int exp_done, input int exp_err,
                           output logic [10:0] cap);
    int inh, rts, edly, d0, e0;
    d0 = n_done;
    e0 = n_err;
    check({tag, "_idle_before"}, 32'(busy), 32'd0);
    do_start(d);
    dev_frame(mode, stop_after, start_at, cap, inh, rts, edly);
    check({tag, "_inhibit_len"}, 32'(inh), 32'(INH));
    check({tag, "_rts_len"}, 32'(rts), 32'd1);
    if (mode == M_STALL) check_range({tag, "_timeout_delay"}, edly, int'(TMO), int'(TMO) + 6);
    repeat (40) tick();
    if (mode == M_ACK || mode == M_NOACK)
      check({tag, "_frame"}, 32'(cap), 32'(model_frame(d)));
    check({tag, "_done_pulses"}, 32'(n_done - d0), 32'(exp_done));
    check({tag, "_err_pulses"}, 32'(n_err - e0), 32'(exp_err));
    check({tag, "_lines_busy_after"}, {29'd0, clk_oe, dat_oe, busy}, 32'd0);
  endtask

  initial begin
    logic [10:0] cap;
    logic [7:0]  rd;
    int          d0, e0;

    rst         = 1'b1;
    start       = 1'b0;
    data        = 8'h00;
    dev_clk_low = 1'b0;
    dev_dat_low = 1'b0;
    repeat (3) tick();
    check("reset_outputs", {26'd0, clk_oe, dat_oe, busy, done, error, rx_inh}, 32'd0);
    rst = 1'b0;
    repeat (3) tick();

    vecs[0] = '{8'hED, M_ACK,   0, 1, 0, 1'b1};
    vecs[1] = '{8'hF4, M_ACK,   0, 1, 0, 1'b0};
    vecs[2] = '{8'h00, M_NOACK, 0, 0, 1, 1'b1};
    vecs[3] = '{8'h55, M_STALL, 3, 0, 1, 1'b1};
    vecs[4] = '{8'hF4, M_ACK,   0, 1, 0, 1'b0};

    foreach (vecs[v]) begin
      run_frame($sformatf("vec%0d", v), vecs[v].data, vecs[v].mode, vecs[v].stop_after,
                0, vecs[v].exp_done, vecs[v].exp_err, cap);
      if (vecs[v].mode != M_STALL) begin
        check($sformatf("vec%0d_parity", v), 32'(cap[9]), 32'(vecs[v].exp_par));
        check($sformatf("vec%0d_stop", v), 32'(cap[10]), 32'd1);
      end
    end

    // Randomized bytes, all acknowledged
    for (int r = 0; r < 6; r++) begin
      rd = 8'($urandom);
      run_frame($sformatf("rand%0d", r), rd, M_ACK, 0, 0, 1, 0, cap);
    end

    // Second Start (0xAA) during XFER must be ignored
    run_frame("restart", 8'hED, M_ACK, 0, 2, 1, 0, cap);

    // Reset in XFER after fe #4 (D3 of 0xF4 is 0, so DatOE is high there)
    d0 = n_done;
    e0 = n_err;
    do_start(8'hF4);
    begin
      int inh, rts, edly;
      dev_frame(M_RESET, 4, 0, cap, inh, rts, edly);
    end
    check("abort_datoe_before", 32'(dat_oe), 32'd1);
    rst = 1'b1;
    tick();
    check("abort_lines_busy", {29'd0, clk_oe, dat_oe, busy}, 32'd0);
    rst         = 1'b0;
    dev_clk_low = 1'b0;
    repeat (40) tick();
    check("abort_no_done", 32'(n_done - d0), 32'd0);
    check("abort_no_err", 32'(n_err - e0), 32'd0);
    run_frame("after_abort", 8'hED, M_ACK, 0, 0, 1, 0, cap);

    check("done_err_exclusive", 32'(n_both), 32'd0);
    check("rxinhibit_eq_busy", 32'(n_rxmis), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
